membus_arbiter: RTL and testbench

//  Shares one memory bus between instruction fetch (read-only, port i_) and memunit (port d_).

---
 rtl/membus_arbiter.sv | 151 +++++++++++++++
 tb/tb_membus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Shares one memory request bus between instruction fetch (i_) and the memory unit (d_),
// remembering who owns each in-flight request so in-order responses route back correctly.
module membus_arbiter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_rvalid,

    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_wen,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_rvalid,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_wen,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    input  logic                    m_rvalid
);

    localparam int PTR_WIDTH    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_WIDTH    = $clog2(MAX_OUTSTANDING + 1);
    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        LOCK_NONE,
        LOCK_I,
        LOCK_D
    } lock_state_t;

    lock_state_t lock_q;
    lock_state_t lock_d;

    logic                    grant_d;
    logic                    grant_valid;
    logic                    handshake;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_owner;
    logic                    starve_at_limit;

    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic [CNT_WIDTH-1:0]    count;
    logic [PTR_WIDTH-1:0]    wr_ptr;
    logic [PTR_WIDTH-1:0]    rd_ptr;
    logic                    owner_mem [MAX_OUTSTANDING];

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full       = (count == CNT_WIDTH'(MAX_OUTSTANDING));
    assign fifo_empty      = (count == '0);
    assign head_owner      = owner_mem[rd_ptr];
    assign starve_at_limit = (starve_cnt == STARVE_WIDTH'(STARVE_LIMIT));

    // A locked owner keeps the bus until memory takes its request, overriding priority.
    always_comb begin
        grant_d = 1'b0;
        lock_d  = lock_q;
        case (lock_q)
            LOCK_I:  grant_d = 1'b0;
            LOCK_D:  grant_d = 1'b1;
            default: grant_d = d_valid && !(i_valid && starve_at_limit);
        endcase

        grant_valid = grant_d ? d_valid : i_valid;
        m_valid     = grant_valid && !fifo_full && !rst;
        handshake   = m_valid && m_ready;
        i_ready     = handshake && !grant_d;
        d_ready     = handshake && grant_d;

        if (handshake) begin
            lock_d = LOCK_NONE;
        end else if (m_valid) begin
            lock_d = grant_d ? LOCK_D : LOCK_I;
        end
    end

    always_comb begin
        m_addr  = grant_d ? d_addr : i_addr;
        m_wen   = grant_d && d_wen;
        m_wdata = grant_d ? d_wdata : '0;
        m_wmask = grant_d ? d_wmask : '0;
    end

    // Responses with nothing outstanding are dropped without touching the owner FIFO.
    assign pop      = m_rvalid && !fifo_empty;
    assign i_rvalid = pop && !head_owner && !rst;
    assign d_rvalid = pop && head_owner && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        if (handshake) begin
            owner_mem[wr_ptr] <= grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counts data grants that jumped ahead of a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!i_valid || i_ready) begin
            starve_cnt <= '0;
        end else if (d_ready && !starve_at_limit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Randomized scoreboard bench for membus_arbiter: a queue-based reference model predicts grants,
// handshakes and response routing; a separate monitor pops expected owners on each response.
module tb_membus_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic          d_valid;
    logic          d_ready;
    logic [AW-1:0] d_addr;
    logic          d_wen;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_wmask;
    logic          d_rvalid;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    logic          m_rvalid;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    int mdl_lock     = -1;
    int mdl_starve   = 0;
    int mdl_inflight = 0;

    int         chk_g;
    bit         chk_mv;
    int         upd_g;
    bit         upd_mv;
    bit         upd_hs;
    logic [1:0] mon_exp;

    always #5 clk = ~clk;

    membus_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MAXO),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_addr(i_addr),
        .i_rvalid(i_rvalid),
        .d_valid(d_valid),
        .d_ready(d_ready),
        .d_addr(d_addr),
        .d_wen(d_wen),
        .d_wdata(d_wdata),
        .d_wmask(d_wmask),
        .d_rvalid(d_rvalid),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr(m_addr),
        .m_wen(m_wen),
        .m_wdata(m_wdata),
        .m_wmask(m_wmask),
        .m_rvalid(m_rvalid)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Owner who should hold the bus: a pending unaccepted request first, then d_ unless i_ is starved.
    function automatic int modelGrant();
        if (mdl_lock >= 0) return mdl_lock;
        if (d_valid && !(i_valid && mdl_starve == SL)) return 1;
        return 0;
    endfunction

    function automatic bit modelMvalid();
        int g;
        g = modelGrant();
        return ((g == 1) ? d_valid : i_valid) && (mdl_inflight < MAXO) && !rst;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_outputs",
                        {59'd0, m_valid, i_ready, d_ready, i_rvalid, d_rvalid}, 64'd0);
        end else begin
            chk_g  = modelGrant();
            chk_mv = modelMvalid();
            checkOutput("m_valid", 64'(m_valid), 64'(chk_mv));
            checkOutput("i_ready", 64'(i_ready), 64'(chk_mv && m_ready && chk_g == 0));
            checkOutput("d_ready", 64'(d_ready), 64'(chk_mv && m_ready && chk_g == 1));
            if (chk_mv) begin
                checkOutput("m_addr", m_addr, (chk_g == 1) ? d_addr : i_addr);
                checkOutput("m_wen", 64'(m_wen), (chk_g == 1) ? 64'(d_wen) : 64'd0);
                checkOutput("m_wdata", m_wdata, (chk_g == 1) ? d_wdata : 64'd0);
                checkOutput("m_wmask", 64'(m_wmask), (chk_g == 1) ? 64'(d_wmask) : 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_rvalid && exp_q.size() > 0) begin
                mon_exp = (exp_q[0] == 0) ? 2'b10 : 2'b01;
                void'(exp_q.pop_front());
            end else begin
                mon_exp = 2'b00;
            end
            checkOutput("rvalid_route", {62'd0, i_rvalid, d_rvalid}, {62'd0, mon_exp});
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mdl_lock     = -1;
            mdl_starve   = 0;
            mdl_inflight = 0;
            exp_q.delete();
        end else begin
            upd_g  = modelGrant();
            upd_mv = modelMvalid();
            upd_hs = upd_mv && m_ready;
            if (m_rvalid && mdl_inflight > 0) mdl_inflight--;
            if (upd_hs) begin
                exp_q.push_back(upd_g);
                mdl_inflight++;
            end
            if (upd_hs) mdl_lock = -1;
            else if (upd_mv) mdl_lock = upd_g;
            if (!i_valid || (upd_hs && upd_g == 0)) mdl_starve = 0;
            else if (upd_hs && upd_g == 1 && mdl_starve < SL) mdl_starve++;
        end
    end

    // One cycle of stimulus: percentages for new i/d requests, m_ready and memory responses.
    task automatic applyStimulus(input int pi, input int pd, input int pr, input int prv,
                                 input bit force_rv, input bit rst_v);
        bit i_took;
        bit d_took;
        @(negedge clk);
        i_took = i_ready;
        d_took = d_ready;
        @(posedge clk);
        #1;
        rst = rst_v;
        if (!i_valid || i_took) begin
            i_valid = ($urandom_range(99) < pi);
            i_addr  = {$urandom, $urandom};
        end
        if (!d_valid || d_took) begin
            d_valid = ($urandom_range(99) < pd);
            d_addr  = {$urandom, $urandom};
            d_wen   = 1'($urandom_range(1));
            d_wdata = {$urandom, $urandom};
            d_wmask = MW'($urandom);
        end
        m_ready  = ($urandom_range(99) < pr);
        m_rvalid = force_rv || (mdl_inflight > 0 && $urandom_range(99) < prv);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pi;
        int pd;
        int pr;
        int prv;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_addr   = '0;
        d_valid  = 1'b0;
        d_addr   = '0;
        d_wen    = 1'b0;
        d_wdata  = '0;
        d_wmask  = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        repeat (3) applyStimulus(0, 0, 0, 0, 1'b0, 1'b1);

        $display("[TB] fetch alone, response two cycles later");
        applyStimulus(100, 0, 100, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 100, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);
        applyStimulus(0, 0, 100, 0, 1'b0, 1'b0);

        $display("[TB] simultaneous fetch and data request");
        applyStimulus(100, 100, 100, 0, 1'b0, 1'b0);
        repeat (4) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);

        $display("[TB] data stream starving fetch");
        repeat (8) applyStimulus(100, 100, 100, 100, 1'b0, 1'b0);
        repeat (5) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);

        $display("[TB] stalled fetch stays locked while data arrives");
        applyStimulus(100, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) applyStimulus(0, 100, 0, 0, 1'b0, 1'b0);
        repeat (2) applyStimulus(0, 0, 100, 0, 1'b0, 1'b0);
        repeat (4) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);

        $display("[TB] owner FIFO full, in-order responses, reset mid-flight");
        applyStimulus(100, 0, 100, 0, 1'b0, 1'b0);
        repeat (3) applyStimulus(0, 100, 100, 0, 1'b0, 1'b0);
        repeat (2) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);
        repeat (3) applyStimulus(100, 100, 100, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 1'b0, 1'b1);
        repeat (2) applyStimulus(0, 0, 0, 0, 1'b1, 1'b0);
        repeat (5) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int b = 0; b < 30; b++) begin
            pi  = int'($urandom_range(100));
            pd  = int'($urandom_range(100));
            pr  = int'($urandom_range(100, 20));
            prv = int'($urandom_range(100, 10));
            for (int c = 0; c < 100; c++) begin
                applyStimulus(pi, pd, pr, prv, 1'b0, ($urandom_range(199) == 0));
            end
        end
        repeat (8) applyStimulus(0, 0, 100, 100, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
